gol_engine: RTL and testbench
=============================

Name: gol_engine

Overview:
- Parametrised Conway Game-of-Life engine: a ROWS x COLS grid, single clock domain.
- Replaces the fixed-size dual-clock datapath.
- Grid is loaded cell-by-cell from button pulses, then advanced one generation per step request.
- Generations are computed row-serially into a shadow buffer and committed atomically. The display/LED driver reads grid_out.

Parameters:
- ROWS, 7, grid rows (>=3)
- COLS, 7, grid columns (>=3)
- GEN_W, 16, generation counter width
- Derived (localparam): N = ROWS*COLS; IDX_W = clog2(N); ROW_W = clog2(ROWS)

Ports:
- clka  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- mode  in  2  00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE
- btn0  in  1  single-cycle pulse (debounced upstream): write 0 at cursor
- btn1  in  1  single-cycle pulse: write 1 at cursor
- step  in  1  single-cycle request to compute one generation
- grid_out  out  N  current grid; cell (r,c) is bit r*COLS+c
- cursor  out  IDX_W  next cell index to program
- busy  out  1  generation computation in progress
- gen_done  out  1  one-cycle pulse on commit
- stable  out  1  last committed generation equalled its predecessor
- gen_count  out  GEN_W  generations committed since IDLE/reset

Behaviour:
- Reset (async, any time): grid_out=0, shadow=0, cursor=0, gen_count=0, busy=0, gen_done=0, stable=0, FSM=S_WAIT.
- IDLE mode (every cycle):
  - Clears grid_out, cursor, gen_count and stable.
  - Aborts any computation: FSM to S_WAIT, busy=0.
- PROGRAM mode:
  - btn0 xor btn1 high: write 0 (btn0) or 1 (btn1) to grid_out[cursor]; cursor+1.
  - Cursor wraps N-1 -> 0.
  - Both buttons high, or neither: no write, no cursor change.
  - step is ignored.
- RUN mode FSM:
  - S_WAIT: step=1 -> S_CALC, row=0, busy=1. step is ignored while busy.
  - S_CALC, one row per cycle: shadow row r = rule(neighbour counts of row r), taken from the unchanged grid_out. row==ROWS-1 -> S_COMMIT, else row+1.
  - S_COMMIT:
    - grid_out <= shadow.
    - stable <= (shadow == grid_out).
    - gen_count+1, wrapping at 2^GEN_W.
    - gen_done=1 for this cycle, busy=0, -> S_WAIT.
  - Latency: step sampled at edge k -> gen_done high in cycle k+ROWS+1 -> next step accepted from cycle k+ROWS+2.
- Rule:
  - Live cell with 2 or 3 live neighbours survives.
  - Dead cell with exactly 3 becomes live.
  - All else dead.
  - Neighbour count is 4 bits (0..8).
- Boundary: cells outside the grid count as dead.
- PAUSE mode:
  - Grid is held; cursor, gen_count and stable are held.
  - An in-flight computation freezes (row held) and resumes on return to RUN.
- Mode change RUN -> PROGRAM while busy: abort, shadow discarded, no gen_done, gen_count unchanged.
- step with mode != RUN: ignored.

Optional Feature:
- Macro GOL_TORUS_EN.
- Defined: edges wrap (toroidal). Row -1 = ROWS-1, column -1 = COLS-1, and symmetrically.
- Undefined: out-of-grid neighbours are dead.
- Latency is identical either way.

Decomposition:
- Package gol_pkg holds:
  - mode encodings MODE_IDLE/PROGRAM/RUN/PAUSE
  - FSM state typedef S_WAIT/S_CALC/S_COMMIT
  - the rule function next_cell(count, alive)
- Sub-module gol_row_calc: combinational.
  - Inputs: rows above, current and below (COLS bits each), plus edge-valid flags.
  - Output: COLS-bit next row.
  - Instantiated once; driven by the row counter mux in gol_engine.

Test Plan:
- 5x5, rst then PROGRAM, 25 button pulses setting bits 11,12,13 -> cursor wraps to 0; grid_out=0x3800.
- Same grid, RUN, step at cycle k:
  - busy high cycles k+1..k+5; gen_done at k+6.
  - grid_out bits {7,12,17}; gen_count=1; stable=0.
  - Second step restores {11,12,13}; gen_count=2.
- 2x2 block at (1,1)-(2,2) on 7x7 -> after step, grid unchanged; stable=1; gen_done pulses once.
- Corners set: cells 0,1,7 on 7x7 without GOL_TORUS_EN -> cell 8 born; result {0,1,7,8}. With GOL_TORUS_EN, 3 cells at 0,6,42 -> cell 48 born.
- Abort:
  - step, then mode->IDLE at k+2 -> no gen_done, grid_out=0, gen_count=0.
  - step, then PAUSE 3 cycles, then RUN -> gen_done delayed exactly 3 cycles.
- rst asserted mid-S_CALC -> all outputs 0 immediately (async); step at/after deassert honoured only in RUN.

Source files
------------

// File: rtl/gol_pkg.sv
// ============================================================================
// gol_pkg : shared mode encodings, FSM state type and the Life rule function
// Revision: 1.0
// ============================================================================
`default_nettype none

package gol_pkg;

    localparam logic [1:0] MODE_IDLE    = 2'b00;
    localparam logic [1:0] MODE_PROGRAM = 2'b01;
    localparam logic [1:0] MODE_RUN     = 2'b10;
    localparam logic [1:0] MODE_PAUSE   = 2'b11;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Survive on 2 or 3 neighbours, birth on exactly 3.
    function automatic logic next_cell(input logic [3:0] count, input logic alive);
        if (alive) begin
            return (count == 4'd2) || (count == 4'd3);
        end
        return (count == 4'd3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gol_row_calc.sv
// ============================================================================
// gol_row_calc : combinational next-state of one grid row from its neighbours
// Horizontal wrap-around is enabled by GOL_TORUS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gol_row_calc
    import gol_pkg::*;
#(
    parameter int COLS = 7
) (
    input  logic [COLS-1:0] i_above,
    input  logic [COLS-1:0] i_cur,
    input  logic [COLS-1:0] i_below,
    input  logic            i_above_vld,
    input  logic            i_below_vld,
    output logic [COLS-1:0] o_next
);

    logic [COLS-1:0] w_a;
    logic [COLS-1:0] w_b;

    assign w_a = i_above & {COLS{i_above_vld}};
    assign w_b = i_below & {COLS{i_below_vld}};

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int CL = (c == 0)        ? COLS - 1 : c - 1;
        localparam int CR = (c == COLS - 1) ? 0        : c + 1;
`ifdef GOL_TORUS_EN
        localparam logic LV = 1'b1;
        localparam logic RV = 1'b1;
`else
        // Left/right neighbours beyond the grid edge count as dead.
        localparam logic LV = (c != 0);
        localparam logic RV = (c != COLS - 1);
`endif
        logic [3:0] w_cnt;

        assign w_cnt = {3'b000, w_a[CL] & LV} + {3'b000, w_a[c]} + {3'b000, w_a[CR] & RV}
                     + {3'b000, i_cur[CL] & LV}                  + {3'b000, i_cur[CR] & RV}
                     + {3'b000, w_b[CL] & LV} + {3'b000, w_b[c]} + {3'b000, w_b[CR] & RV};

        assign o_next[c] = next_cell(w_cnt, i_cur[c]);
    end

endmodule

`default_nettype wire

// File: rtl/gol_engine.sv
// ============================================================================
// gol_engine : ROWS x COLS Game-of-Life engine, row-serial with atomic commit
// Optional toroidal edges via GOL_TORUS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gol_engine
    import gol_pkg::*;
#(
    parameter  int ROWS  = 7,
    parameter  int COLS  = 7,
    parameter  int GEN_W = 16,
    localparam int N     = ROWS * COLS,
    localparam int IDX_W = $clog2(N),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic             clka,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             btn0,
    input  logic             btn1,
    input  logic             step,
    output logic [N-1:0]     grid_out,
    output logic [IDX_W-1:0] cursor,
    output logic             busy,
    output logic             gen_done,
    output logic             stable,
    output logic [GEN_W-1:0] gen_count
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           r_state;
    logic [ROW_W-1:0] r_row;
    logic [N-1:0]     r_grid;
    logic [N-1:0]     r_shadow;
    logic [IDX_W-1:0] r_cursor;
    logic             r_busy;
    logic             r_gen_done;
    logic             r_stable;
    logic [GEN_W-1:0] r_gen_count;

    logic [ROW_W-1:0] w_row_up;
    logic [ROW_W-1:0] w_row_dn;
    logic             w_above_vld;
    logic             w_below_vld;
    logic [COLS-1:0]  w_above;
    logic [COLS-1:0]  w_cur;
    logic [COLS-1:0]  w_below;
    logic [COLS-1:0]  w_next_row;
    logic [N-1:0]     w_commit;

    always_comb begin
        w_row_up = (r_row == '0)       ? LAST_ROW : r_row - ROW_ONE;
        w_row_dn = (r_row == LAST_ROW) ? '0       : r_row + ROW_ONE;
`ifdef GOL_TORUS_EN
        w_above_vld = 1'b1;
        w_below_vld = 1'b1;
`else
        w_above_vld = (r_row != '0);
        w_below_vld = (r_row != LAST_ROW);
`endif
    end

    assign w_above = r_grid[int'(w_row_up) * COLS +: COLS];
    assign w_cur   = r_grid[int'(r_row)    * COLS +: COLS];
    assign w_below = r_grid[int'(w_row_dn) * COLS +: COLS];

    gol_row_calc #(
        .COLS (COLS)
    ) u_row_calc (
        .i_above     (w_above),
        .i_cur       (w_cur),
        .i_below     (w_below),
        .i_above_vld (w_above_vld),
        .i_below_vld (w_below_vld),
        .o_next      (w_next_row)
    );

    // The last row is merged in directly so grid_out changes on the same edge
    // that raises gen_done; a consumer sampling on gen_done sees the new grid.
    always_comb begin
        w_commit = r_shadow;
        w_commit[(ROWS - 1) * COLS +: COLS] = w_next_row;
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state     <= S_WAIT;
            r_row       <= '0;
            r_grid      <= '0;
            r_shadow    <= '0;
            r_cursor    <= '0;
            r_busy      <= 1'b0;
            r_gen_done  <= 1'b0;
            r_stable    <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_gen_done <= 1'b0;
            case (mode)
                MODE_IDLE: begin
                    r_state     <= S_WAIT;
                    r_busy      <= 1'b0;
                    r_grid      <= '0;
                    r_cursor    <= '0;
                    r_gen_count <= '0;
                    r_stable    <= 1'b0;
                end
                MODE_PROGRAM: begin
                    r_state <= S_WAIT;
                    r_busy  <= 1'b0;
                    if (btn0 ^ btn1) begin
                        r_grid[r_cursor] <= btn1;
                        r_cursor         <= (r_cursor == LAST_IDX) ? '0 : r_cursor + IDX_ONE;
                    end
                end
                MODE_RUN: begin
                    case (r_state)
                        S_WAIT: begin
                            if (step) begin
                                r_state <= S_CALC;
                                r_row   <= '0;
                                r_busy  <= 1'b1;
                            end
                        end
                        S_CALC: begin
                            r_shadow[int'(r_row) * COLS +: COLS] <= w_next_row;
                            if (r_row == LAST_ROW) begin
                                r_grid      <= w_commit;
                                r_stable    <= (w_commit == r_grid);
                                r_gen_count <= r_gen_count + GEN_W'(1);
                                r_gen_done  <= 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= S_COMMIT;
                            end else begin
                                r_row <= r_row + ROW_ONE;
                            end
                        end
                        S_COMMIT: begin
                            r_state <= S_WAIT;
                        end
                        default: begin
                            r_state <= S_WAIT;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    // Pause freezes an in-flight calculation; a finished commit retires.
                    if (r_state == S_COMMIT) begin
                        r_state <= S_WAIT;
                    end
                end
            endcase
        end
    end

    assign grid_out  = r_grid;
    assign cursor    = r_cursor;
    assign busy      = r_busy;
    assign gen_done  = r_gen_done;
    assign stable    = r_stable;
    assign gen_count = r_gen_count;

endmodule

`default_nettype wire

// File: tb/tb_gol_engine.sv
// ============================================================================
// tb_gol_engine : randomized scoreboard bench for gol_engine (7x7, flat edges)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gol_engine;
    import gol_pkg::*;

    localparam int ROWS  = 7;
    localparam int COLS  = 7;
    localparam int GEN_W = 16;
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode = MODE_IDLE;
    logic             btn0 = 1'b0;
    logic             btn1 = 1'b0;
    logic             step = 1'b0;
    logic [N-1:0]     grid_out;
    logic [IDX_W-1:0] cursor;
    logic             busy;
    logic             gen_done;
    logic             stable;
    logic [GEN_W-1:0] gen_count;

    gol_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
        .clka      (clk),
        .rst       (rst),
        .mode      (mode),
        .btn0      (btn0),
        .btn1      (btn1),
        .step      (step),
        .grid_out  (grid_out),
        .cursor    (cursor),
        .busy      (busy),
        .gen_done  (gen_done),
        .stable    (stable),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [N-1:0]     grid;
        logic [GEN_W-1:0] gen;
        logic             stable;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [N-1:0]     m_grid = '0;
    logic [GEN_W-1:0] m_gen  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain neighbour counting over the whole grid, outside cells dead.
    function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
        logic [N-1:0] n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                            if (g[rr * COLS + cc]) cnt++;
                    end
                end
                if (g[r * COLS + c]) n[r * COLS + c] = (cnt == 2 || cnt == 3);
                else                 n[r * COLS + c] = (cnt == 3);
            end
        end
        return n;
    endfunction

    // Monitor: every gen_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && gen_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_gen_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("gen_grid",   64'(grid_out),  64'(e.grid));
                chk("gen_count",  64'(gen_count), 64'(e.gen));
                chk("gen_stable", 64'(stable),    64'(e.stable));
                chk("gen_cycle",  64'(cyc),       64'(e.cyc));
                chk("gen_busy",   64'(busy),      64'd0);
            end
        end
    end

    task automatic set_mode(input logic [1:0] m);
        @(posedge clk); #1;
        mode = m;
    endtask

    task automatic press(input logic b0, input logic b1);
        @(posedge clk); #1;
        btn0 = b0; btn1 = b1;
        @(posedge clk); #1;
        btn0 = 1'b0; btn1 = 1'b0;
    endtask

    task automatic load_grid(input logic [N-1:0] g);
        set_mode(MODE_IDLE);
        set_mode(MODE_PROGRAM);
        m_grid = '0;
        m_gen  = '0;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) press(1'b1, 1'b1);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1 step = 1'b1;
                @(posedge clk); #1 step = 1'b0;
            end
            press(!g[i], g[i]);
        end
        m_grid = g;
        chk("load_grid",   64'(grid_out), 64'(g));
        chk("load_cursor", 64'(cursor),   64'd0);
    endtask

    // Issue one step pulse; optionally queue the expected commit.
    task automatic issue_step(input bit push, input logic exp_busy, input int pause_len);
        int p;
        @(posedge clk); #1;
        step = 1'b1;
        p = cyc;
        if (push) begin
            exp_t e;
            e.grid   = life_next(m_grid);
            e.gen    = m_gen + GEN_W'(1);
            e.stable = (e.grid == m_grid);
            e.cyc    = p + 1 + ROWS + pause_len;
            sb.push_back(e);
            m_grid = e.grid;
            m_gen  = e.gen;
        end
        @(posedge clk); #1;
        step = 1'b0;
        chk("busy_after_step", 64'(busy), 64'(exp_busy));
    endtask

    task automatic pause_for(input int len);
        if (len > 0) begin
            set_mode(MODE_PAUSE);
            repeat (len - 1) @(posedge clk);
            set_mode(MODE_RUN);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk); #1;
        if (sb.size() != 0) begin
            chk("gen_done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_grid"},   64'(grid_out),  64'd0);
        chk({name, "_cursor"}, 64'(cursor),    64'd0);
        chk({name, "_busy"},   64'(busy),      64'd0);
        chk({name, "_done"},   64'(gen_done),  64'd0);
        chk({name, "_stable"}, 64'(stable),    64'd0);
        chk({name, "_gen"},    64'(gen_count), 64'd0);
    endtask

    initial begin
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Horizontal blinker on row 3 flips vertical and back.
        load_grid((N'(1) << 23) | (N'(1) << 24) | (N'(1) << 25));
        set_mode(MODE_RUN);
        issue_step(1'b1, 1'b1, 0);
        issue_step(1'b0, 1'b1, 0);
        drain();
        chk("blinker_vertical", 64'(grid_out), 64'((N'(1) << 17) | (N'(1) << 24) | (N'(1) << 31)));
        issue_step(1'b1, 1'b1, 0);
        drain();
        chk("blinker_back", 64'(grid_out), 64'((N'(1) << 23) | (N'(1) << 24) | (N'(1) << 25)));

        // Still-life block.
        load_grid((N'(1) << 8) | (N'(1) << 9) | (N'(1) << 15) | (N'(1) << 16));
        set_mode(MODE_RUN);
        issue_step(1'b1, 1'b1, 0);
        drain();
        chk("block_stable", 64'(stable), 64'd1);

        // Corner birth with dead outer boundary.
        load_grid((N'(1) << 0) | (N'(1) << 1) | (N'(1) << 7));
        set_mode(MODE_RUN);
        issue_step(1'b1, 1'b1, 0);
        drain();
        chk("corner_birth", 64'(grid_out), 64'(N'(32'h183)));

        // Pause for three cycles delays commit by exactly three cycles.
        issue_step(1'b1, 1'b1, 3);
        pause_for(3);
        drain();

        // RUN -> PROGRAM while busy aborts without side effects.
        issue_step(1'b0, 1'b1, 0);
        set_mode(MODE_PROGRAM);
        repeat (ROWS + 3) @(posedge clk);
        #1;
        chk("abort_prog_grid", 64'(grid_out),  64'(m_grid));
        chk("abort_prog_gen",  64'(gen_count), 64'(m_gen));
        chk("abort_prog_busy", 64'(busy),      64'd0);
        set_mode(MODE_RUN);
        issue_step(1'b1, 1'b1, 0);
        drain();

        // RUN -> IDLE while busy aborts and clears.
        issue_step(1'b0, 1'b1, 0);
        set_mode(MODE_IDLE);
        repeat (ROWS + 3) @(posedge clk);
        #1 check_zero("abort_idle");
        m_grid = '0;
        m_gen  = '0;

        // Randomized grids, random step pacing and pauses.
        for (int t = 0; t < 6; t++) begin
            logic [N-1:0] g;
            for (int i = 0; i < N; i++) g[i] = ($urandom_range(0, 2) == 0);
            load_grid(g);
            set_mode(MODE_RUN);
            for (int s = 0; s < 3; s++) begin
                int len;
                len = $urandom_range(0, 3);
                issue_step(1'b1, 1'b1, len);
                pause_for(len);
                drain();
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end

        // Async reset during calculation, then step outside RUN is ignored.
        issue_step(1'b0, 1'b1, 0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1 check_zero("mid_calc_reset");
        m_grid = '0;
        m_gen  = '0;
        mode = MODE_PROGRAM;
        @(posedge clk); #1;
        rst = 1'b0;
        issue_step(1'b0, 1'b0, 0);
        repeat (ROWS + 3) @(posedge clk);
        set_mode(MODE_RUN);
        issue_step(1'b1, 1'b1, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
